// File: rtl/pusch_dr_lane_deskew.sv
// ============================================================================
// Module   : pusch_dr_lane_deskew
// Purpose  : Multi-lane deskew stage. Per-lane FIFOs are released in lockstep
//            once every active lane presents SOP, with masking, lagging-lane
//            timeout/exclusion and sticky per-lane overflow flags.
//            Optional build macro PUSCH_DR_DESKEW_STAT_EN adds o_skew_max.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pusch_dr_lane_deskew #(
    parameter int LANE  = 8,
    parameter int DW    = 64,
    parameter int DEPTH = 64,
    parameter int TMO   = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [LANE-1:0]      i_lane_mask,
    input  logic [LANE*DW-1:0]   i_rx_data,
    input  logic [LANE-1:0]      i_rx_vld,
    input  logic [LANE-1:0]      i_rx_sop,
    output logic [LANE*DW-1:0]   o_data,
    output logic                 o_vld,
    output logic                 o_sop,
    output logic [LANE-1:0]      o_lane_ok,
    output logic                 o_tmo,
    output logic [LANE-1:0]      o_ovf,
    output logic                 o_busy
`ifdef PUSCH_DR_DESKEW_STAT_EN
    ,
    output logic [15:0]          o_skew_max
`endif
);

    localparam int AW     = $clog2(DEPTH);
    localparam int TW_RAW = $clog2(TMO + 1);
    localparam int TW     = (TW_RAW > 10) ? TW_RAW : 10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [TW-1:0] C_TMO_LAST = TW'(TMO - 1);

    logic [1:0]          state_q, state_d;
    logic [LANE-1:0]     act_q, act_d;
    logic [LANE-1:0]     part_q, part_d;
    logic [LANE-1:0]     ovf_q, ovf_d;
    logic [LANE-1:0]     ok_q, ok_d;
    logic                first_q, first_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                vld_q, vld_d;
    logic                sop_q, sop_d;
    logic                tmo_q, tmo_d;
    logic [LANE*DW-1:0]  data_q, data_d;
    logic [AW:0]         wp_q [LANE];
    logic [AW:0]         wp_d [LANE];
    logic [AW:0]         rp_q [LANE];
    logic [AW:0]         rp_d [LANE];

    logic [LANE-1:0]     ne, full, hsop, pop, wr_req, wr_en;
    logic [DW:0]         head [LANE];

    // Per-lane FIFO storage: entry = {sop, data}; head is read combinationally.
    for (genvar gl = 0; gl < LANE; gl++) begin : g_lane
        logic [DW:0] mem_q [DEPTH];

        always_ff @(posedge i_clk) begin
            if (wr_en[gl]) begin
                mem_q[wp_q[gl][AW-1:0]] <= {i_rx_sop[gl], i_rx_data[gl*DW +: DW]};
            end
        end

        assign head[gl] = mem_q[rp_q[gl][AW-1:0]];
    end

    always_comb begin
        ne     = '0;
        full   = '0;
        hsop   = '0;
        wr_req = '0;
        for (int l = 0; l < LANE; l++) begin
            ne[l]     = (wp_q[l] != rp_q[l]);
            full[l]   = (wp_q[l][AW] != rp_q[l][AW]) &&
                        (wp_q[l][AW-1:0] == rp_q[l][AW-1:0]);
            hsop[l]   = head[l][DW];
            wr_req[l] = i_rx_vld[l] & i_lane_mask[l];
        end
    end

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        part_d  = part_q;
        timer_d = timer_q;
        first_d = first_q;
        pop     = '0;
        tmo_d   = 1'b0;
        vld_d   = 1'b0;
        sop_d   = 1'b0;
        data_d  = data_q;
        ok_d    = ok_q;
        case (state_q)
            S_IDLE: begin
                if (|i_lane_mask) begin
                    act_d   = i_lane_mask;
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                pop = act_q & ne & ~hsop;
                if ((act_q & ne & hsop) == act_q) begin
                    part_d  = act_q;
                    first_d = 1'b1;
                    state_d = S_RUN;
                end else if (timer_q == C_TMO_LAST) begin
                    // Lagging lanes are dropped from this packet only.
                    tmo_d   = 1'b1;
                    part_d  = act_q & ne & hsop;
                    first_d = 1'b1;
                    state_d = (|(act_q & ne & hsop)) ? S_RUN : S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RUN: begin
                if (!first_q && |(part_q & ne & hsop)) begin
                    act_d   = i_lane_mask;
                    timer_d = '0;
                    state_d = (|i_lane_mask) ? S_WAIT : S_IDLE;
                end else if ((part_q & ne) == part_q) begin
                    pop     = part_q;
                    vld_d   = 1'b1;
                    sop_d   = first_q;
                    first_d = 1'b0;
                    ok_d    = part_q;
                    for (int l = 0; l < LANE; l++) begin
                        data_d[l*DW +: DW] = part_q[l] ? head[l][DW-1:0] : '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop on a full FIFO frees the slot the concurrent write lands in.
    always_comb begin
        wr_en = '0;
        ovf_d = ovf_q;
        for (int l = 0; l < LANE; l++) begin
            wr_en[l] = wr_req[l] & (~full[l] | pop[l]);
            ovf_d[l] = ovf_q[l] | (wr_req[l] & full[l] & ~pop[l]);
            wp_d[l]  = wp_q[l] + {{AW{1'b0}}, wr_en[l]};
            rp_d[l]  = rp_q[l] + {{AW{1'b0}}, pop[l]};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            act_q   <= '0;
            part_q  <= '0;
            ovf_q   <= '0;
            ok_q    <= '0;
            first_q <= 1'b0;
            timer_q <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            tmo_q   <= 1'b0;
            data_q  <= '0;
            for (int l = 0; l < LANE; l++) begin
                wp_q[l] <= '0;
                rp_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            part_q  <= part_d;
            ovf_q   <= ovf_d;
            ok_q    <= ok_d;
            first_q <= first_d;
            timer_q <= timer_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            for (int l = 0; l < LANE; l++) begin
                wp_q[l] <= wp_d[l];
                rp_q[l] <= rp_d[l];
            end
        end
    end

`ifdef PUSCH_DR_DESKEW_STAT_EN
    logic [15:0] skew_q, skew_d;
    logic [31:0] wait_cycles;
    logic [15:0] wait_sat;

    always_comb begin
        skew_d      = skew_q;
        wait_cycles = 32'(timer_q) + 32'd1;
        wait_sat    = (wait_cycles > 32'h0000_FFFF) ? 16'hFFFF : wait_cycles[15:0];
        if ((state_q == S_WAIT) && (state_d != S_WAIT) && (wait_sat > skew_q)) begin
            skew_d = wait_sat;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            skew_q <= '0;
        end else begin
            skew_q <= skew_d;
        end
    end

    assign o_skew_max = skew_q;
`else
    // Skew statistics not built.
`endif

    assign o_data    = data_q;
    assign o_vld     = vld_q;
    assign o_sop     = sop_q;
    assign o_lane_ok = ok_q;
    assign o_tmo     = tmo_q;
    assign o_ovf     = ovf_q;
    assign o_busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pusch_dr_lane_deskew.sv
// ============================================================================
// Module   : tb_pusch_dr_lane_deskew
// Purpose  : Directed self-checking bench for pusch_dr_lane_deskew.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pusch_dr_lane_deskew;

    localparam int LANE = 8;
    localparam int DW   = 16;
    localparam int TMO  = 16;

    logic clk;
    logic rst_n;

    logic [LANE-1:0]    a_mask, a_vld, a_sop, a_ok, a_ovf;
    logic [LANE*DW-1:0] a_data, a_odata;
    logic               a_ovld, a_osop, a_tmo, a_busy;
    logic [LANE-1:0]    b_mask, b_vld, b_sop, b_ok, b_ovf;
    logic [LANE*DW-1:0] b_data, b_odata;
    logic               b_ovld, b_osop, b_tmo, b_busy;
`ifdef PUSCH_DR_DESKEW_STAT_EN
    logic [15:0]        a_skew, b_skew;
`endif

    int errors = 0;
    int checks = 0;

    int vld_cnt, sop_cnt, tmo_cnt, first_vld, tmo_t, sop_idx;
    logic [LANE*DW-1:0] cap_data [8];
    logic [LANE-1:0]    cap_ok   [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pusch_dr_lane_deskew #(.LANE(LANE), .DW(DW), .DEPTH(16), .TMO(TMO)) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_lane_mask(a_mask), .i_rx_data(a_data),
        .i_rx_vld(a_vld), .i_rx_sop(a_sop), .o_data(a_odata), .o_vld(a_ovld),
        .o_sop(a_osop), .o_lane_ok(a_ok), .o_tmo(a_tmo), .o_ovf(a_ovf), .o_busy(a_busy)
`ifdef PUSCH_DR_DESKEW_STAT_EN
        , .o_skew_max(a_skew)
`endif
    );

    pusch_dr_lane_deskew #(.LANE(LANE), .DW(DW), .DEPTH(4), .TMO(TMO)) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_lane_mask(b_mask), .i_rx_data(b_data),
        .i_rx_vld(b_vld), .i_rx_sop(b_sop), .o_data(b_odata), .o_vld(b_ovld),
        .o_sop(b_osop), .o_lane_ok(b_ok), .o_tmo(b_tmo), .o_ovf(b_ovf), .o_busy(b_busy)
`ifdef PUSCH_DR_DESKEW_STAT_EN
        , .o_skew_max(b_skew)
`endif
    );

    function automatic logic [15:0] enc(input int l, input int p, input int i);
        enc = {l[3:0], p[3:0], i[7:0]};
    endfunction

    function automatic logic [LANE*DW-1:0] exp_beat(input logic [7:0] lanes, input int p, input int i);
        exp_beat = '0;
        for (int l = 0; l < LANE; l++) begin
            if (lanes[l]) exp_beat[l*DW +: DW] = enc(l, p, i);
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        a_mask = '0; a_vld = '0; a_sop = '0; a_data = '0;
        b_mask = '0; b_vld = '0; b_sop = '0; b_data = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic clear_cap;
        vld_cnt = 0; sop_cnt = 0; tmo_cnt = 0;
        first_vld = -1; tmo_t = -1; sop_idx = -1;
        for (int i = 0; i < 8; i++) begin
            cap_data[i] = '0;
            cap_ok[i]   = '0;
        end
    endtask

    task automatic sample_a(input int t);
        if (a_ovld) begin
            if (vld_cnt < 8) begin
                cap_data[vld_cnt] = a_odata;
                cap_ok[vld_cnt]   = a_ok;
            end
            if (first_vld < 0) first_vld = t;
            if (a_osop && sop_idx < 0) sop_idx = vld_cnt;
            vld_cnt++;
        end
        if (a_osop) sop_cnt++;
        if (a_tmo) begin
            tmo_cnt++;
            if (tmo_t < 0) tmo_t = t;
        end
    endtask

    // Lane k's 8-beat packet starts at cycle garbage3 + k*stagger; lane 3
    // optionally emits non-SOP garbage beats before that.
    task automatic run_a(input logic [7:0] send, input int stagger, input int pkt,
                         input int garbage3, input int ncyc);
        clear_cap();
        a_mask = 8'hFF;
        for (int t = 0; t < ncyc; t++) begin
            a_vld = '0; a_sop = '0; a_data = '0;
            for (int k = 0; k < LANE; k++) begin
                int i;
                i = t - garbage3 - k * stagger;
                if (send[k] && i >= 0 && i < 8) begin
                    a_vld[k] = 1'b1;
                    a_sop[k] = (i == 0);
                    a_data[k*DW +: DW] = enc(k, pkt, i);
                end else if (k == 3 && t < garbage3) begin
                    a_vld[k] = 1'b1;
                    a_data[k*DW +: DW] = enc(3, 15, t);
                end
            end
            tick();
            sample_a(t);
        end
        a_vld = '0; a_sop = '0; a_data = '0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if ({a_ovld, a_osop, a_tmo, a_busy} !== 4'b0) begin errors++; $display("FAIL reset_a_ctrl: got %b expected 0000", {a_ovld, a_osop, a_tmo, a_busy}); end
        checks++; if (a_odata !== '0) begin errors++; $display("FAIL reset_a_data: got %h expected 0", a_odata); end
        checks++; if ({a_ok, a_ovf} !== 16'h0) begin errors++; $display("FAIL reset_a_ok_ovf: got %h expected 0000", {a_ok, a_ovf}); end
        checks++; if ({b_ovld, b_osop, b_tmo, b_busy, b_ok, b_ovf} !== 20'h0) begin errors++; $display("FAIL reset_b: got %h expected 0", {b_ovld, b_osop, b_tmo, b_busy, b_ok, b_ovf}); end
    endtask

    task automatic test_skew;
        do_reset();
        run_a(8'hFF, 1, 1, 0, 32);
        checks++; if (sop_cnt !== 1) begin errors++; $display("FAIL skew_sop_cnt: got %0d expected 1", sop_cnt); end
        checks++; if (vld_cnt !== 8) begin errors++; $display("FAIL skew_vld_cnt: got %0d expected 8", vld_cnt); end
        checks++; if (sop_idx !== 0) begin errors++; $display("FAIL skew_sop_pos: got %0d expected 0", sop_idx); end
        checks++; if (first_vld !== 9) begin errors++; $display("FAIL skew_latency: got %0d expected 9", first_vld); end
        checks++; if (tmo_cnt !== 0) begin errors++; $display("FAIL skew_tmo: got %0d expected 0", tmo_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_data[i] !== exp_beat(8'hFF, 1, i)) begin errors++; $display("FAIL skew_beat%0d: got %h expected %h", i, cap_data[i], exp_beat(8'hFF, 1, i)); end
        end
        checks++; if ({cap_ok[0], cap_ok[7]} !== 16'hFFFF) begin errors++; $display("FAIL skew_lane_ok: got %h expected ffff", {cap_ok[0], cap_ok[7]}); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL skew_busy: got %b expected 1", a_busy); end
    endtask

    task automatic test_garbage;
        do_reset();
        run_a(8'hFF, 0, 2, 2, 24);
        checks++; if ({sop_cnt, vld_cnt, tmo_cnt} !== {32'd1, 32'd8, 32'd0}) begin errors++; $display("FAIL garbage_counts: got sop=%0d vld=%0d tmo=%0d expected 1 8 0", sop_cnt, vld_cnt, tmo_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_data[i] !== exp_beat(8'hFF, 2, i)) begin errors++; $display("FAIL garbage_beat%0d: got %h expected %h", i, cap_data[i], exp_beat(8'hFF, 2, i)); end
        end
    endtask

    task automatic test_timeout;
        do_reset();
        run_a(8'hDF, 0, 3, 0, 40);
        checks++; if (tmo_cnt !== 1) begin errors++; $display("FAIL tmo_cnt: got %0d expected 1", tmo_cnt); end
        checks++; if (tmo_t !== 16) begin errors++; $display("FAIL tmo_time: got %0d expected 16", tmo_t); end
        checks++; if ({sop_cnt, vld_cnt} !== {32'd1, 32'd8}) begin errors++; $display("FAIL tmo_counts: got sop=%0d vld=%0d expected 1 8", sop_cnt, vld_cnt); end
        checks++; if (cap_ok[0] !== 8'hDF) begin errors++; $display("FAIL tmo_lane_ok: got %h expected df", cap_ok[0]); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (cap_data[i] !== exp_beat(8'hDF, 3, i)) begin errors++; $display("FAIL tmo_beat%0d: got %h expected %h", i, cap_data[i], exp_beat(8'hDF, 3, i)); end
        end
    endtask

    task automatic test_rejoin;
        run_a(8'hFF, 0, 4, 0, 24);
        checks++; if ({sop_cnt, vld_cnt, tmo_cnt} !== {32'd1, 32'd8, 32'd0}) begin errors++; $display("FAIL rejoin_counts: got sop=%0d vld=%0d tmo=%0d expected 1 8 0", sop_cnt, vld_cnt, tmo_cnt); end
        checks++; if ({cap_ok[0], cap_ok[7]} !== 16'hFFFF) begin errors++; $display("FAIL rejoin_lane_ok: got %h expected ffff", {cap_ok[0], cap_ok[7]}); end
        checks++; if (cap_data[0] !== exp_beat(8'hFF, 4, 0)) begin errors++; $display("FAIL rejoin_beat0: got %h expected %h", cap_data[0], exp_beat(8'hFF, 4, 0)); end
        checks++; if (cap_data[7] !== exp_beat(8'hFF, 4, 7)) begin errors++; $display("FAIL rejoin_beat7: got %h expected %h", cap_data[7], exp_beat(8'hFF, 4, 7)); end
    endtask

    task automatic test_overflow;
        int bv, bs;
        logic [LANE*DW-1:0] exp_last;
        do_reset();
        b_mask = 8'h03;
        bv = 0; bs = 0;
        exp_last = '0;
        exp_last[0 +: DW]  = enc(0, 5, 5);
        exp_last[DW +: DW] = enc(1, 5, 4);
        for (int t = 0; t < 18; t++) begin
            b_vld = '0; b_sop = '0; b_data = '0;
            if (t <= 4 || t == 14) begin
                b_vld[0] = 1'b1;
                b_sop[0] = (t == 0);
                b_data[0 +: DW] = enc(0, 5, (t == 14) ? 5 : t);
            end
            if (t == 5 || (t >= 7 && t <= 13) || t == 15) begin
                b_vld[1] = 1'b1;
                b_sop[1] = (t == 5);
                b_data[DW +: DW] = enc(1, 5, (t == 5) ? 0 : ((t == 15) ? 8 : t - 6));
            end
            tick();
            if (b_ovld) bv++;
            if (b_osop) bs++;
            if (t == 3) begin
                checks++; if (b_ovf !== 8'h00) begin errors++; $display("FAIL ovf_before_full: got %h expected 00", b_ovf); end
            end
            if (t == 4) begin
                checks++; if (b_ovf !== 8'h01) begin errors++; $display("FAIL ovf_set: got %h expected 01", b_ovf); end
            end
            if (t == 15) begin
                checks++; if (b_ovld !== 1'b1) begin errors++; $display("FAIL ovf_fullrw_vld: got %b expected 1", b_ovld); end
                checks++; if (b_odata !== exp_last) begin errors++; $display("FAIL ovf_fullrw_data: got %h expected %h", b_odata, exp_last); end
                checks++; if (b_ok !== 8'h03) begin errors++; $display("FAIL ovf_lane_ok: got %h expected 03", b_ok); end
            end
        end
        b_vld = '0; b_sop = '0; b_data = '0;
        checks++; if (b_ovf !== 8'h01) begin errors++; $display("FAIL ovf_sticky: got %h expected 01", b_ovf); end
        checks++; if ({bv, bs} !== {32'd5, 32'd1}) begin errors++; $display("FAIL ovf_beats: got vld=%0d sop=%0d expected 5 1", bv, bs); end
    endtask

    task automatic test_reset_mid_run;
        do_reset();
        a_mask = 8'hFF;
        for (int t = 0; t < 4; t++) begin
            a_vld = 8'hFF;
            a_sop = (t == 0) ? 8'hFF : 8'h00;
            a_data = exp_beat(8'hFF, 6, t);
            tick();
        end
        checks++; if (a_ovld !== 1'b1) begin errors++; $display("FAIL midrst_pre_vld: got %b expected 1", a_ovld); end
        a_vld = '0; a_sop = '0; a_data = '0;
        rst_n = 1'b0;
        tick();
        checks++; if ({a_ovld, a_osop, a_tmo, a_busy} !== 4'b0) begin errors++; $display("FAIL midrst_ctrl: got %b expected 0000", {a_ovld, a_osop, a_tmo, a_busy}); end
        checks++; if ({a_odata, a_ok, a_ovf} !== '0) begin errors++; $display("FAIL midrst_data: got %h expected 0", {a_odata, a_ok, a_ovf}); end
        rst_n = 1'b1;
        run_a(8'hFF, 0, 7, 0, 24);
        checks++; if ({sop_cnt, vld_cnt} !== {32'd1, 32'd8}) begin errors++; $display("FAIL midrst_counts: got sop=%0d vld=%0d expected 1 8", sop_cnt, vld_cnt); end
        checks++; if (cap_data[0] !== exp_beat(8'hFF, 7, 0)) begin errors++; $display("FAIL midrst_beat0: got %h expected %h", cap_data[0], exp_beat(8'hFF, 7, 0)); end
        checks++; if (cap_data[7] !== exp_beat(8'hFF, 7, 7)) begin errors++; $display("FAIL midrst_beat7: got %h expected %h", cap_data[7], exp_beat(8'hFF, 7, 7)); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_skew();
        test_garbage();
        test_timeout();
        test_rejoin();
        test_overflow();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
